// File: rtl/clasificacion_vcn.sv
// Routes each input word by its embedded class field into one of NUM_VC independent FIFOs.
// Optional macro DROP_CNT_EN adds per-VC 8-bit saturating overflow-drop counters (drop_cnt_vc).

module clasificacion_vcn_fifo #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   af_th,
  input  logic [ADDR_SIZE:0]   ae_th,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 empty,
  output logic                 full,
  output logic                 pause,
  output logic                 almost_empty,
  output logic                 error
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);
  localparam int DEPTH = 2**ADDR_SIZE;
  localparam int CW    = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] FULL_CNT = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   cnt;
  logic [ADDR_SIZE:0]   cnt_nxt;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 overflow;
  logic                 underflow;

  // A pop on a full FIFO frees the slot the same-cycle push writes into.
  always_comb begin
    pop_ok    = pop && (cnt != '0);
    push_ok   = push && ((cnt != FULL_CNT) || pop_ok);
    overflow  = push && !push_ok;
    underflow = pop && !pop_ok;
    cnt_nxt   = cnt;
    if (push_ok && !pop_ok) begin
      cnt_nxt = cnt + CW'(1);
    end else if (!push_ok && pop_ok) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      rdata        <= '0;
      rvalid       <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      pause        <= 1'b0;
      almost_empty <= 1'b1;
      error        <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
        rdata  <= mem[rd_ptr];
      end
      rvalid       <= pop_ok;
      cnt          <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      full         <= (cnt_nxt == FULL_CNT);
      pause        <= (cnt_nxt >= af_th);
      almost_empty <= (cnt_nxt <= ae_th);
      if (overflow || underflow) begin
        error <= 1'b1;
      end
    end
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      drop_cnt <= '0;
    end else if (overflow && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

module clasificacion_vcn #(
  parameter int DATA_SIZE = 10,
  parameter int VC_SEL_W  = 1,
  parameter int SEL_LSB   = 8,
  parameter int ADDR_SIZE = 3,
  localparam int NUM_VC   = 2**VC_SEL_W
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        valid_in,
  input  logic [DATA_SIZE-1:0]        datain_class,
  input  logic [ADDR_SIZE:0]          afVC_o,
  input  logic [ADDR_SIZE:0]          aeVC_o,
  input  logic [NUM_VC-1:0]           pop_vc,
  output logic [NUM_VC*DATA_SIZE-1:0] data_vc,
  output logic [NUM_VC-1:0]           valid_vc,
  output logic [NUM_VC-1:0]           fifo_empty_vc,
  output logic [NUM_VC-1:0]           fifo_full_vc,
  output logic [NUM_VC-1:0]           fifo_pause_vc,
  output logic [NUM_VC-1:0]           fifo_ae_vc,
  output logic [NUM_VC-1:0]           fifo_error_vc
`ifdef DROP_CNT_EN
  ,
  output logic [NUM_VC*8-1:0]         drop_cnt_vc
`endif
);
  logic                 stage_vld;
  logic [DATA_SIZE-1:0] stage_word;
  logic [VC_SEL_W-1:0]  stage_sel;

  // Class stage: the word is kept whole, class bits included.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      stage_vld  <= 1'b0;
      stage_word <= '0;
      stage_sel  <= '0;
    end else begin
      stage_vld <= valid_in;
      if (valid_in) begin
        stage_word <= datain_class;
        stage_sel  <= datain_class[SEL_LSB +: VC_SEL_W];
      end
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic push_i;
    assign push_i = stage_vld && (stage_sel == VC_SEL_W'(i));

    clasificacion_vcn_fifo #(
      .DATA_SIZE(DATA_SIZE),
      .ADDR_SIZE(ADDR_SIZE)
    ) u_fifo (
      .clk          (clk),
      .reset_L      (reset_L),
      .push         (push_i),
      .wdata        (stage_word),
      .pop          (pop_vc[i]),
      .af_th        (afVC_o),
      .ae_th        (aeVC_o),
      .rdata        (data_vc[i*DATA_SIZE +: DATA_SIZE]),
      .rvalid       (valid_vc[i]),
      .empty        (fifo_empty_vc[i]),
      .full         (fifo_full_vc[i]),
      .pause        (fifo_pause_vc[i]),
      .almost_empty (fifo_ae_vc[i]),
      .error        (fifo_error_vc[i])
`ifdef DROP_CNT_EN
      ,
      .drop_cnt     (drop_cnt_vc[i*8 +: 8])
`endif
    );
  end

endmodule
